// File: rtl/panic_perf_monitor_if.sv
// panic_perf_monitor_if: snooped AXIS handshakes, control and register read port of the perf monitor
interface panic_perf_monitor_if #(
  parameter int AXIS_KEEP_WIDTH = 32,
  parameter int CLASS_WIDTH = 5
);
  logic [AXIS_KEEP_WIDTH-1:0] s_rx_axis_tkeep;
  logic s_rx_axis_tvalid, s_rx_axis_tready, s_rx_axis_tlast;
  logic [CLASS_WIDTH-1:0] s_flow_class;
  logic [15:0] s_pk_len;
  logic [AXIS_KEEP_WIDTH-1:0] m_rx_axis_tkeep;
  logic m_rx_axis_tvalid, m_rx_axis_tready, m_rx_axis_tlast;
  logic cfg_clear, cfg_freeze, rd_en;
  logic [7:0] rd_addr;
  logic [31:0] rd_data;
  logic rd_valid, window_done;
  modport master (
    output s_rx_axis_tkeep, s_rx_axis_tvalid, s_rx_axis_tready, s_rx_axis_tlast, s_flow_class, s_pk_len,
    output m_rx_axis_tkeep, m_rx_axis_tvalid, m_rx_axis_tready, m_rx_axis_tlast,
    output cfg_clear, cfg_freeze, rd_en, rd_addr,
    input rd_data, rd_valid, window_done
  );
  modport slave (
    input s_rx_axis_tkeep, s_rx_axis_tvalid, s_rx_axis_tready, s_rx_axis_tlast, s_flow_class, s_pk_len,
    input m_rx_axis_tkeep, m_rx_axis_tvalid, m_rx_axis_tready, m_rx_axis_tlast,
    input cfg_clear, cfg_freeze, rd_en, rd_addr,
    output rd_data, rd_valid, window_done
  );
endinterface

// File: rtl/panic_perf_monitor.sv
// panic_perf_monitor: passive AXIS perf counters with windowed per-class stats and a register read port
module panic_perf_monitor #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int NUM_CLASS = 5,
  parameter int CLASS_WIDTH = 5,
  parameter int WINDOW_LOG2 = 10
) (
  input logic clk,
  input logic rst,
  panic_perf_monitor_if.slave bus
);
  typedef struct packed {
    logic [63:0] cycle_cnt;
    logic [31:0] in_frames, out_frames, in_pkts, out_pkts, oor_frames, win_count;
    logic [47:0] in_bytes, out_bytes, win_len_sum, last_len_sum;
    logic [31:0] win_pkt_cnt, last_pkt_cnt, win_out, last_out, max_out;
    logic [NUM_CLASS-1:0][31:0] win_in, last_in, max_in;
    logic [WINDOW_LOG2-1:0] wcnt;
  } stats_t;
  stats_t st, nx;
  logic run, in_beat, out_beat, in_pkt, out_pkt, oor, close;
  logic [AXIS_KEEP_WIDTH-1:0] in_keep, out_keep;
  logic [47:0] len_nxt;
  logic [31:0] pkt_nxt, out_nxt, rd_mux;
  logic [NUM_CLASS-1:0][31:0] in_nxt;
  assign run = ~bus.cfg_freeze;
  assign in_beat = run & bus.s_rx_axis_tvalid & bus.s_rx_axis_tready;
  assign out_beat = run & bus.m_rx_axis_tvalid & bus.m_rx_axis_tready;
  assign in_pkt = in_beat & bus.s_rx_axis_tlast;
  assign out_pkt = out_beat & bus.m_rx_axis_tlast;
  assign oor = int'(bus.s_flow_class) >= NUM_CLASS;
  assign close = run & (&st.wcnt);
  assign in_keep = bus.s_rx_axis_tkeep;
  assign out_keep = bus.m_rx_axis_tkeep;
  // next values include this cycle's beat so a beat in the closing cycle lands in the snapshot
  assign len_nxt = st.win_len_sum + (in_pkt ? 48'(bus.s_pk_len) : 48'd0);
  assign pkt_nxt = st.win_pkt_cnt + 32'(in_pkt);
  assign out_nxt = st.win_out + 32'(out_beat);
  always_comb begin
    nx = st;
    in_nxt = '0;
    nx.cycle_cnt = st.cycle_cnt + 64'(run);
    nx.wcnt = st.wcnt + WINDOW_LOG2'(run);
    nx.in_frames = st.in_frames + 32'(in_beat);
    nx.out_frames = st.out_frames + 32'(out_beat);
    nx.in_pkts = st.in_pkts + 32'(in_pkt);
    nx.out_pkts = st.out_pkts + 32'(out_pkt);
    nx.oor_frames = st.oor_frames + 32'(in_beat & oor);
    nx.in_bytes = st.in_bytes + (in_beat ? 48'($countones(in_keep)) : 48'd0);
    nx.out_bytes = st.out_bytes + (out_beat ? 48'($countones(out_keep)) : 48'd0);
    nx.win_count = st.win_count + 32'(close);
    nx.win_len_sum = close ? '0 : len_nxt;
    nx.last_len_sum = close ? len_nxt : st.last_len_sum;
    nx.win_pkt_cnt = close ? '0 : pkt_nxt;
    nx.last_pkt_cnt = close ? pkt_nxt : st.last_pkt_cnt;
    nx.win_out = close ? '0 : out_nxt;
    nx.last_out = close ? out_nxt : st.last_out;
    nx.max_out = close && out_nxt > st.max_out ? out_nxt : st.max_out;
    for (int c = 0; c < NUM_CLASS; c++) begin
      in_nxt[c] = st.win_in[c] + 32'(in_beat && bus.s_flow_class == CLASS_WIDTH'(c));
      nx.win_in[c] = close ? '0 : in_nxt[c];
      nx.last_in[c] = close ? in_nxt[c] : st.last_in[c];
      nx.max_in[c] = close && in_nxt[c] > st.max_in[c] ? in_nxt[c] : st.max_in[c];
    end
  end
  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr)
      8'h00: rd_mux = st.cycle_cnt[31:0];
      8'h01: rd_mux = st.cycle_cnt[63:32];
      8'h02: rd_mux = st.in_frames;
      8'h03: rd_mux = st.out_frames;
      8'h04: rd_mux = st.in_pkts;
      8'h05: rd_mux = st.out_pkts;
      8'h06: rd_mux = st.in_bytes[31:0];
      8'h07: rd_mux = 32'(st.in_bytes[47:32]);
      8'h08: rd_mux = st.out_bytes[31:0];
      8'h09: rd_mux = 32'(st.out_bytes[47:32]);
      8'h0A: rd_mux = st.oor_frames;
      8'h0B: rd_mux = st.win_count;
      8'h0C: rd_mux = st.last_len_sum[31:0];
      8'h0D: rd_mux = 32'(st.last_len_sum[47:32]);
      8'h0E: rd_mux = st.last_pkt_cnt;
      8'h0F: rd_mux = st.last_out;
      8'h30: rd_mux = st.max_out;
      8'h31: rd_mux = {8'(NUM_CLASS), 8'(WINDOW_LOG2), 16'h9A71};
      default: rd_mux = '0;
    endcase
    for (int c = 0; c < NUM_CLASS; c++) begin
      rd_mux = bus.rd_addr == 8'(16 + c) ? st.last_in[c] : rd_mux;
      rd_mux = bus.rd_addr == 8'(32 + c) ? st.max_in[c] : rd_mux;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
      bus.window_done <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      st <= bus.cfg_clear ? '0 : nx;
      bus.window_done <= close & ~bus.cfg_clear;
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_panic_perf_monitor.sv
// tb_panic_perf_monitor: directed checks of totals, window snapshots, freeze/clear and the read port
module tb_panic_perf_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int wd_n;
  localparam logic [31:0] ID = 32'h0504_9A71;
  panic_perf_monitor_if #(.AXIS_KEEP_WIDTH(32), .CLASS_WIDTH(5)) bus ();
  panic_perf_monitor #(
    .AXIS_DATA_WIDTH(256), .AXIS_KEEP_WIDTH(32), .NUM_CLASS(5), .CLASS_WIDTH(5), .WINDOW_LOG2(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_v"}, 64'(bus.rd_valid), 64'd1);
    chk(tag, 64'(bus.rd_data), 64'(exp));
  endtask
  task automatic set_in(input logic v, input logic [4:0] cls, input logic last, input logic [15:0] len);
    bus.s_rx_axis_tvalid = v;
    bus.s_rx_axis_tready = 1'b1;
    bus.s_flow_class = cls;
    bus.s_rx_axis_tlast = last;
    bus.s_pk_len = len;
  endtask
  task automatic set_out(input logic v);
    bus.m_rx_axis_tvalid = v;
    bus.m_rx_axis_tready = 1'b1;
    bus.m_rx_axis_tlast = 1'b1;
    bus.m_rx_axis_tkeep = 32'h0000_000F;
  endtask
  initial begin
    bus.s_rx_axis_tkeep = '1;
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    set_out(1'b0);
    bus.cfg_clear = 1'b0;
    bus.cfg_freeze = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_addr = 8'h00;
    idle(2);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_wd", 64'(bus.window_done), 64'd0);
    rst = 1'b0;
    // two windows of continuous class-2 ingress and 4-byte egress packets
    set_in(1'b1, 5'd2, 1'b0, 16'd0);
    set_out(1'b1);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("a_wd%0d", i), 64'(bus.window_done), 64'(i % 16 == 0));
    end
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    set_out(1'b0);
    bus.cfg_freeze = 1'b1;
    rd(8'h00, 32'd32, "a_cyc");
    rd(8'h01, 32'd0, "a_cyc_hi");
    rd(8'h02, 32'd32, "a_in_frames");
    rd(8'h03, 32'd32, "a_out_frames");
    rd(8'h05, 32'd32, "a_out_pkts");
    rd(8'h06, 32'd1024, "a_in_bytes_lo");
    rd(8'h07, 32'd0, "a_in_bytes_hi");
    rd(8'h08, 32'd128, "a_out_bytes");
    rd(8'h0B, 32'd2, "a_win_count");
    rd(8'h12, 32'd16, "a_last_in2");
    rd(8'h22, 32'd16, "a_max_in2");
    rd(8'h0F, 32'd16, "a_last_out");
    rd(8'h30, 32'd16, "a_max_out");
    // single class-1 beat only in the closing cycle
    bus.cfg_freeze = 1'b0;
    idle(15);
    set_in(1'b1, 5'd1, 1'b0, 16'd0);
    tick();
    chk("b_wd0", 64'(bus.window_done), 64'd1);
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    bus.cfg_freeze = 1'b1;
    rd(8'h11, 32'd1, "b_last_in1");
    rd(8'h21, 32'd1, "b_max_in1");
    rd(8'h12, 32'd0, "b_last_in2");
    rd(8'h22, 32'd16, "b_max_in2");
    rd(8'h0F, 32'd0, "b_last_out");
    rd(8'h30, 32'd16, "b_max_out");
    bus.cfg_freeze = 1'b0;
    idle(16);
    chk("b_wd1", 64'(bus.window_done), 64'd1);
    bus.cfg_freeze = 1'b1;
    rd(8'h11, 32'd0, "b_last_in1_w1");
    rd(8'h21, 32'd1, "b_max_in1_w1");
    // three packets in one window
    bus.cfg_freeze = 1'b0;
    set_in(1'b1, 5'd0, 1'b1, 16'd64);
    tick();
    set_in(1'b1, 5'd0, 1'b1, 16'd1500);
    tick();
    set_in(1'b1, 5'd0, 1'b1, 16'd9000);
    tick();
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    idle(13);
    chk("c_wd", 64'(bus.window_done), 64'd1);
    bus.cfg_freeze = 1'b1;
    rd(8'h0C, 32'd10564, "c_len_sum_lo");
    rd(8'h0D, 32'd0, "c_len_sum_hi");
    rd(8'h0E, 32'd3, "c_pkt_cnt");
    rd(8'h04, 32'd3, "c_in_pkts");
    rd(8'h10, 32'd3, "c_last_in0");
    // out-of-range class
    bus.cfg_freeze = 1'b0;
    set_in(1'b1, 5'd7, 1'b0, 16'd0);
    idle(5);
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    idle(11);
    chk("d_wd", 64'(bus.window_done), 64'd1);
    bus.cfg_freeze = 1'b1;
    rd(8'h0A, 32'd5, "d_oor");
    rd(8'h02, 32'd41, "d_in_frames");
    for (int c = 0; c < 5; c++) rd(8'(16 + c), 32'd0, $sformatf("d_last_in%0d", c));
    // freeze with traffic
    rd(8'h00, 32'd96, "e_cyc_pre");
    set_in(1'b1, 5'd2, 1'b1, 16'd100);
    set_out(1'b1);
    wd_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      wd_n += int'(bus.window_done);
    end
    chk("e_wd_n", 64'(wd_n), 64'd0);
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    set_out(1'b0);
    rd(8'h00, 32'd96, "e_cyc");
    rd(8'h02, 32'd41, "e_in_frames");
    rd(8'h03, 32'd32, "e_out_frames");
    rd(8'h04, 32'd3, "e_in_pkts");
    rd(8'h0B, 32'd6, "e_win_count");
    // clear coinciding with a window close and a read
    bus.cfg_freeze = 1'b0;
    idle(15);
    set_in(1'b1, 5'd2, 1'b0, 16'd0);
    bus.cfg_clear = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'h0B;
    tick();
    bus.cfg_clear = 1'b0;
    bus.rd_en = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 16'd0);
    bus.cfg_freeze = 1'b1;
    chk("clr_wd", 64'(bus.window_done), 64'd0);
    chk("clr_rd_pre", 64'(bus.rd_data), 64'd6);
    tick();
    chk("clr_wd2", 64'(bus.window_done), 64'd0);
    for (int a = 0; a <= 'h31; a++) rd(8'(a), a == 'h31 ? ID : 32'd0, $sformatf("clr_%02h", a));
    // back-to-back reads, hold, async reset mid-read
    bus.cfg_freeze = 1'b0;
    idle(5);
    bus.cfg_freeze = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'h00;
    tick();
    chk("f_v0", 64'(bus.rd_valid), 64'd1);
    chk("f_d0", 64'(bus.rd_data), 64'd5);
    bus.rd_addr = 8'h31;
    tick();
    chk("f_v1", 64'(bus.rd_valid), 64'd1);
    chk("f_d1", 64'(bus.rd_data), 64'(ID));
    bus.rd_addr = 8'h7F;
    tick();
    chk("f_v2", 64'(bus.rd_valid), 64'd1);
    chk("f_d2", 64'(bus.rd_data), 64'd0);
    bus.rd_addr = 8'h31;
    tick();
    bus.rd_en = 1'b0;
    tick();
    chk("f_hold_v", 64'(bus.rd_valid), 64'd0);
    chk("f_hold_d", 64'(bus.rd_data), 64'(ID));
    bus.rd_en = 1'b1;
    tick();
    chk("g_v_pre", 64'(bus.rd_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("g_rst_v", 64'(bus.rd_valid), 64'd0);
    chk("g_rst_d", 64'(bus.rd_data), 64'd0);
    bus.rd_en = 1'b0;
    tick();
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/panic_perf_monitor.md
Name: panic_perf_monitor

Overview:
- Parametrised, software-readable successor to the fixed five-class perf counter.
- Passively snoops the ingress AXIS (wire side) and egress AXIS (DMA side) handshakes. Accumulates:
  - cycle, frame, packet and byte totals;
  - per-class windowed frame counts with running maxima;
  - per-window packet-length sum and count.
- Results are exposed through a 1-cycle-latency register read port, with clear and freeze controls. Sits beside the PANIC RX datapath; never drives the AXIS buses.

Parameters:
AXIS_DATA_WIDTH, 256, snooped data width (bits); only tkeep is used.
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
NUM_CLASS, 5, number of flow classes tracked, 1..16.
CLASS_WIDTH, 5, width of s_flow_class.
WINDOW_LOG2, 10, window length = 2**WINDOW_LOG2 cycles, 4..20.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_rx_axis_tkeep  in  AXIS_KEEP_WIDTH  ingress byte enables
s_rx_axis_tvalid  in  1  ingress valid
s_rx_axis_tready  in  1  ingress ready
s_rx_axis_tlast  in  1  ingress last
s_flow_class  in  CLASS_WIDTH  class of current ingress beat
s_pk_len  in  16  packet length, sampled on ingress last beat
m_rx_axis_tkeep  in  AXIS_KEEP_WIDTH  egress byte enables
m_rx_axis_tvalid  in  1  egress valid
m_rx_axis_tready  in  1  egress ready
m_rx_axis_tlast  in  1  egress last
cfg_clear  in  1  one-cycle pulse: zero all statistics
cfg_freeze  in  1  level: hold all statistics
rd_en  in  1  read strobe
rd_addr  in  8  register index
rd_data  out  32  read data
rd_valid  out  1  read data valid
window_done  out  1  one-cycle pulse when a window closes

Behaviour:
- Reset is asynchronous and active-high on rst. All counters, snapshots, maxima, rd_data, rd_valid and window_done are 0.
- Beat events:
  - In beat = s_rx_axis_tvalid & s_rx_axis_tready.
  - Out beat = m_rx_axis_tvalid & m_rx_axis_tready.
  - Packet = beat & tlast.
  - Bytes per beat = popcount(tkeep).
- Totals (wrap modulo width):
  - cycle_cnt: 64 bits, +1 every non-frozen cycle.
  - in_frames, out_frames, in_pkts, out_pkts: 32 bits each.
  - in_bytes, out_bytes: 48 bits each.
- Window counter:
  - WINDOW_LOG2 bits, +1 every non-frozen cycle.
  - The window closes in the cycle the counter equals all-ones; the counter then wraps to 0.
- Per-class live counters win_in[c] (32 bits): +1 on an in beat with s_flow_class == c.
  - Class >= NUM_CLASS counts only toward totals and oor_frames (32 bits).
- Per-window length accumulation on an in packet: win_len_sum (48 bits) += s_pk_len and win_pkt_cnt (32 bits) += 1.
- Window close:
  - A beat or packet in the closing cycle counts toward the closing window; it is folded into the snapshot and not lost.
  - last_in[c] <= win_in[c] + this-cycle increment.
  - max_in[c] <= max(max_in[c], that value).
  - Same for last_out/max_out from win_out, and last_len_sum/last_pkt_cnt.
  - Live window counters then restart at 0.
  - window_done = 1 for exactly that cycle. It is registered: it asserts one cycle after the all-ones count.
  - win_count (32 bits) +1.
- Freeze: while cfg_freeze = 1, no counter, snapshot or maximum changes. Beats are ignored. Reads still work.
- Clear: cfg_clear zeroes every statistic and the window counter on the next edge. It has priority over freeze and over window close; window_done is suppressed that cycle.
- Read port:
  - rd_en at edge N gives rd_data/rd_valid at edge N+1. rd_valid is a one-cycle pulse.
  - Back-to-back reads are allowed.
  - rd_data holds its last value when rd_valid = 0.
  - Reads reflect register state before any update in the same cycle.
- Register map (unmapped indices read 0):
  - 0x00/0x01: cycle_cnt lo/hi.
  - 0x02–0x05: in_frames, out_frames, in_pkts, out_pkts.
  - 0x06/0x07: in_bytes lo/hi.
  - 0x08/0x09: out_bytes lo/hi.
  - 0x0A: oor_frames.
  - 0x0B: win_count.
  - 0x0C/0x0D: last_len_sum lo/hi.
  - 0x0E: last_pkt_cnt.
  - 0x0F: last_out.
  - 0x10+c: last_in[c].
  - 0x20+c: max_in[c].
  - 0x30: max_out.
  - 0x31: constant {NUM_CLASS[7:0], WINDOW_LOG2[7:0], 16'h9A71}.
- Reset mid-window discards the partial window. cfg_clear mid-read returns the pre-clear value.

Test Plan:
- WINDOW_LOG2=4, continuous class-2 in beats, tkeep all-ones:
  - window_done every 16 cycles;
  - last_in[2] = 16 and max_in[2] = 16;
  - in_bytes after 2 windows = 1024.
- Single class-1 beat only in the closing cycle of window 0 → last_in[1] = 1 after window 0; 0x11 reads 0 after window 1; max_in[1] stays 1.
- Three in packets with s_pk_len 64, 1500, 9000 in one window → last_len_sum = 10564, last_pkt_cnt = 3, in_pkts = 3.
- Class 7 beats with NUM_CLASS=5 → oor_frames and in_frames increment; all last_in[c] stay 0.
- Assert cfg_freeze for 40 cycles with traffic → cycle_cnt and all counters are unchanged, and window_done never asserts. Then pulse cfg_clear together with a window close → every read returns 0 (except 0x31) and no window_done.
- Back-to-back rd_en to 0x00, 0x31, 0x7F → three consecutive rd_valid pulses, correct values, third = 0. Async rst mid-read → rd_valid and rd_data are 0 immediately.
